// File: rtl/dtw_sdtw_core_pkg.sv
// ---------------------------------------------------------------------------
// dtw_sdtw_core_pkg
// Shared definitions for the serial subsequence-DTW engine: default sizes,
// the FSM state encoding and small elaboration-time helpers (address width,
// saturation/INF value of a cost word).
// ---------------------------------------------------------------------------
package dtw_sdtw_core_pkg;

  localparam int SAMPLE_W_DEF  = 8;
  localparam int COST_W_DEF    = 16;
  localparam int REF_LEN_DEF   = 16;
  localparam int QUERY_LEN_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ROW   = 2'd2,
    ST_DONE  = 2'd3
  } dtw_state_e;

  // Index width for a table of n entries; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = (n > 1) ? $clog2(n) : 1;
    return w;
  endfunction

  // All-ones value of a w-bit cost word: doubles as INF and saturation level.
  function automatic logic [63:0] cost_inf(input int w);
    logic [63:0] v;
    v = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    return v;
  endfunction

endpackage

// File: rtl/dtw_sdtw_core_if.sv
// ---------------------------------------------------------------------------
// dtw_sdtw_core_if
// Bundles the FIFO pop port, reference write port, run control and result
// signals of the DTW engine.
//   master : upstream side (FIFO, reference loader, controller)
//   slave  : the DTW core
// Signals:
//   dtw_fifo_dout/empty/rden  head-of-FIFO sample, empty flag, pop strobe
//   ref_wr_en/addr/data       reference array write port (IDLE only)
//   start/busy/done           run control and status
//   result_cost/result_pos    minimum last-row cost and its column
// ---------------------------------------------------------------------------
interface dtw_sdtw_core_if
  import dtw_sdtw_core_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int REF_LEN  = REF_LEN_DEF,
  parameter int COST_W   = COST_W_DEF
);
  localparam int ADDR_W = clog2_min1(REF_LEN);

  logic [SAMPLE_W-1:0] dtw_fifo_dout;
  logic                dtw_fifo_empty;
  logic                dtw_fifo_rden;
  logic                ref_wr_en;
  logic [ADDR_W-1:0]   ref_wr_addr;
  logic [SAMPLE_W-1:0] ref_wr_data;
  logic                start;
  logic                busy;
  logic                done;
  logic [COST_W-1:0]   result_cost;
  logic [ADDR_W-1:0]   result_pos;

  modport master (
    output dtw_fifo_dout, dtw_fifo_empty, ref_wr_en, ref_wr_addr, ref_wr_data, start,
    input  dtw_fifo_rden, busy, done, result_cost, result_pos
  );

  modport slave (
    input  dtw_fifo_dout, dtw_fifo_empty, ref_wr_en, ref_wr_addr, ref_wr_data, start,
    output dtw_fifo_rden, busy, done, result_cost, result_pos
  );
endinterface

// File: rtl/dtw_sdtw_core_cell.sv
// ---------------------------------------------------------------------------
// dtw_sdtw_core_cell
// Purely combinational DP cell:
//   cell = sat( |q - ref| + min(diag, up, left) )
// Ports:
//   i_q, i_ref             query and reference samples
//   i_diag, i_up, i_left   neighbouring accumulated costs
//   o_cell                 saturated accumulated cost of this cell
// ---------------------------------------------------------------------------
module dtw_sdtw_core_cell
  import dtw_sdtw_core_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int COST_W   = COST_W_DEF
) (
  input  logic [SAMPLE_W-1:0] i_q,
  input  logic [SAMPLE_W-1:0] i_ref,
  input  logic [COST_W-1:0]   i_diag,
  input  logic [COST_W-1:0]   i_up,
  input  logic [COST_W-1:0]   i_left,
  output logic [COST_W-1:0]   o_cell
);
  localparam logic [COST_W-1:0] INF = COST_W'(cost_inf(COST_W));

  logic [SAMPLE_W:0] w_diff;
  logic [COST_W-1:0] w_min_du;
  logic [COST_W-1:0] w_min3;
  logic [COST_W:0]   w_sum;

  // Absolute difference, three-way minimum and saturating accumulate.
  always_comb begin
    w_diff   = '0;
    w_min_du = '0;
    w_min3   = '0;
    w_sum    = '0;
    o_cell   = '0;

    // One extra bit so the subtraction never wraps.
    if (i_q >= i_ref) begin
      w_diff = {1'b0, i_q} - {1'b0, i_ref};
    end else begin
      w_diff = {1'b0, i_ref} - {1'b0, i_q};
    end

    if (i_diag <= i_up) begin
      w_min_du = i_diag;
    end else begin
      w_min_du = i_up;
    end

    if (w_min_du <= i_left) begin
      w_min3 = w_min_du;
    end else begin
      w_min3 = i_left;
    end

    // Carry out of COST_W bits means the true sum is beyond range: clamp.
    w_sum = (COST_W + 1)'(w_diff) + {1'b0, w_min3};
    if (w_sum[COST_W]) begin
      o_cell = INF;
    end else begin
      o_cell = w_sum[COST_W-1:0];
    end
  end

endmodule

// File: rtl/dtw_sdtw_core.sv
// ---------------------------------------------------------------------------
// dtw_sdtw_core
// Serial subsequence-DTW engine. Pops one query sample per row from the
// upstream sample FIFO, sweeps it across the locally stored reference one DP
// cell per clock and reports the minimum last-row cost and its column.
// Row -1 is all zeros (free start anywhere in the reference); column -1 is
// INF except for the corner D[-1][-1] = 0.
// Ports:
//   S_AXIS_ACLK     clock, shared with the stream sink
//   S_AXIS_ARESETN  asynchronous active-low reset
//   bus             dtw_sdtw_core_if.slave: FIFO pop, reference write,
//                   start/busy/done, result_cost/result_pos
// ---------------------------------------------------------------------------
module dtw_sdtw_core
  import dtw_sdtw_core_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int REF_LEN   = REF_LEN_DEF,
  parameter int QUERY_LEN = QUERY_LEN_DEF,
  parameter int COST_W    = COST_W_DEF
) (
  input  logic            S_AXIS_ACLK,
  input  logic            S_AXIS_ARESETN,
  dtw_sdtw_core_if.slave  bus
);
  localparam int ADDR_W = clog2_min1(REF_LEN);
  localparam int ROW_W  = clog2_min1(QUERY_LEN);

  localparam logic [COST_W-1:0] INF      = COST_W'(cost_inf(COST_W));
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(REF_LEN - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(QUERY_LEN - 1);

  dtw_state_e          r_state;
  logic [ROW_W-1:0]    r_i;
  logic [ADDR_W-1:0]   r_j;
  logic [SAMPLE_W-1:0] r_q;
  logic [COST_W-1:0]   r_diag;
  logic [COST_W-1:0]   r_left;
  logic [COST_W-1:0]   r_min;
  logic [ADDR_W-1:0]   r_pos;
  logic                r_busy;
  logic                r_done;
  logic [COST_W-1:0]   r_res_cost;
  logic [ADDR_W-1:0]   r_res_pos;

  // Storage arrays are intentionally not reset.
  logic [SAMPLE_W-1:0] r_ref  [REF_LEN];
  logic [COST_W-1:0]   r_prev [REF_LEN];

  logic [COST_W-1:0]   w_up;
  logic [COST_W-1:0]   w_cell;
  logic                w_take_min;
  logic [COST_W-1:0]   w_min_next;
  logic [ADDR_W-1:0]   w_pos_next;

  // Pop only while fetching and only when a sample is actually there.
  assign bus.dtw_fifo_rden = (r_state == ST_FETCH) && !bus.dtw_fifo_empty;

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result_cost = r_res_cost;
  assign bus.result_pos  = r_res_pos;

  // Up neighbour and running last-row minimum for the current cell.
  always_comb begin
    w_up       = '0;
    w_take_min = 1'b0;
    w_min_next = r_min;
    w_pos_next = r_pos;

    if (r_i == '0) begin
      w_up = '0;
    end else begin
      w_up = r_prev[r_j];
    end

    // Column 0 seeds the minimum; afterwards strict less-than keeps the
    // lowest index on ties.
    if ((r_i == LAST_ROW) && ((r_j == '0) || (w_cell < r_min))) begin
      w_take_min = 1'b1;
    end else begin
      w_take_min = 1'b0;
    end

    if (w_take_min) begin
      w_min_next = w_cell;
      w_pos_next = r_j;
    end else begin
      w_min_next = r_min;
      w_pos_next = r_pos;
    end
  end

  dtw_sdtw_core_cell #(
    .SAMPLE_W (SAMPLE_W),
    .COST_W   (COST_W)
  ) u_cell (
    .i_q    (r_q),
    .i_ref  (r_ref[r_j]),
    .i_diag (r_diag),
    .i_up   (w_up),
    .i_left (r_left),
    .o_cell (w_cell)
  );

  // Reference writes are accepted only while idle.
  always_ff @(posedge S_AXIS_ACLK) begin
    if ((r_state == ST_IDLE) && bus.ref_wr_en) begin
      r_ref[bus.ref_wr_addr] <= bus.ref_wr_data;
    end
  end

  // Previous-row buffer: each computed cell overwrites its column.
  always_ff @(posedge S_AXIS_ACLK) begin
    if (r_state == ST_ROW) begin
      r_prev[r_j] <= w_cell;
    end
  end

  // Control FSM with registered status and result outputs.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_state    <= ST_IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_q        <= '0;
      r_diag     <= '0;
      r_left     <= '0;
      r_min      <= '0;
      r_pos      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_res_cost <= '0;
      r_res_pos  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_FETCH;
            r_busy  <= 1'b1;
            r_i     <= '0;
          end
        end

        ST_FETCH: begin
          if (!bus.dtw_fifo_empty) begin
            r_q     <= bus.dtw_fifo_dout;
            r_j     <= '0;
            // Corner D[-1][-1] is 0 only for the first row.
            r_diag  <= (r_i == '0) ? '0 : INF;
            r_left  <= INF;
            r_state <= ST_ROW;
          end
        end

        ST_ROW: begin
          // This cell's up becomes the next cell's diagonal.
          r_diag <= w_up;
          r_left <= w_cell;
          r_min  <= w_min_next;
          r_pos  <= w_pos_next;
          if (r_j == LAST_COL) begin
            if (r_i == LAST_ROW) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_res_cost <= w_min_next;
              r_res_pos  <= w_pos_next;
            end else begin
              r_i     <= r_i + ROW_W'(1'b1);
              r_state <= ST_FETCH;
            end
          end else begin
            r_j <= r_j + ADDR_W'(1'b1);
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_sdtw_core.sv
// ---------------------------------------------------------------------------
// tb_dtw_sdtw_core
// Scoreboard bench for dtw_sdtw_core (REF_LEN=4, QUERY_LEN=2, COST_W=8).
// Stimulus pushes hand-computed expectations; a monitor pops and compares
// them whenever done is seen. A small FIFO model feeds query samples.
// ---------------------------------------------------------------------------
module tb_dtw_sdtw_core;
  localparam int SW = 8;
  localparam int RL = 4;
  localparam int QL = 2;
  localparam int CW = 8;
  localparam int AW = 2;

  typedef struct {
    string         name;
    logic [CW-1:0] cost;
    logic [AW-1:0] pos;
    int            lat;
    int            pops;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dtw_sdtw_core_if #(.SAMPLE_W(SW), .REF_LEN(RL), .COST_W(CW)) ifc ();

  dtw_sdtw_core #(
    .SAMPLE_W  (SW),
    .REF_LEN   (RL),
    .QUERY_LEN (QL),
    .COST_W    (CW)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .bus            (ifc)
  );

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [SW-1:0] fifo_q[$];
  int            stall_req = 0;
  int            stall_left = 0;
  int            cyc = 0;
  int            t_start = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            pops_seen = 0;
  int            viol = 0;
  logic          pop_flag;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // FIFO model: pops on a sampled rden, optional forced-empty window.
  initial begin
    ifc.dtw_fifo_dout  = '0;
    ifc.dtw_fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      pop_flag = ifc.dtw_fifo_rden;
      @(posedge clk);
      #1;
      if (pop_flag && (fifo_q.size() > 0)) void'(fifo_q.pop_front());
      if (stall_req > 0) begin
        stall_left = stall_req;
        stall_req  = 0;
      end
      ifc.dtw_fifo_empty = (fifo_q.size() == 0) || (stall_left > 0);
      ifc.dtw_fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
      if (stall_left > 0) stall_left--;
    end
  end

  // Monitor: count pops, flag illegal pops, score each done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pops_seen = 0;
        viol      = 0;
      end else begin
        if (ifc.dtw_fifo_rden) begin
          pops_seen++;
          if (ifc.dtw_fifo_empty || !ifc.busy) viol++;
        end
        if (ifc.done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk({mon_e.name, "_cost"}, ifc.result_cost, mon_e.cost);
            chk({mon_e.name, "_pos"}, ifc.result_pos, mon_e.pos);
            chk({mon_e.name, "_done_cycle"}, cyc - t_start + 1, mon_e.lat);
            chk({mon_e.name, "_rden_pulses"}, pops_seen, mon_e.pops);
            chk({mon_e.name, "_illegal_rden"}, viol, 0);
          end
          pops_seen = 0;
          viol      = 0;
        end
      end
    end
  end

  task automatic load_ref(input logic [SW-1:0] a, input logic [SW-1:0] b,
                          input logic [SW-1:0] c, input logic [SW-1:0] d);
    logic [SW-1:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int k = 0; k < 4; k++) begin
      ifc.ref_wr_en   = 1'b1;
      ifc.ref_wr_addr = AW'(k);
      ifc.ref_wr_data = v[k];
      @(negedge clk);
    end
    ifc.ref_wr_en = 1'b0;
  endtask

  task automatic run(input string name, input logic [SW-1:0] q0, input logic [SW-1:0] q1,
                     input logic [CW-1:0] c, input logic [AW-1:0] p, input int lat);
    exp_t e;
    fifo_q.push_back(q0);
    fifo_q.push_back(q1);
    e.name = name; e.cost = c; e.pos = p; e.lat = lat; e.pops = 2;
    exp_q.push_back(e);
    repeat (2) @(negedge clk);
    ifc.start = 1'b1;
    t_start   = cyc + 1;
    @(negedge clk);
    ifc.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((exp_q.size() > 0) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_timeout"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.start       = 1'b0;
    ifc.ref_wr_en   = 1'b0;
    ifc.ref_wr_addr = '0;
    ifc.ref_wr_data = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_cost", ifc.result_cost, 0);
    chk("rst_pos", ifc.result_pos, 0);
    chk("rst_rden", ifc.dtw_fifo_rden, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: rows [10,0,10,20] / [30,10,0,10].
    load_ref(8'd10, 8'd20, 8'd30, 8'd40);
    run("basic", 8'd20, 8'd30, 8'd0, 2'd2, 11);
    wait_done("basic");

    // Ten-cycle forced-empty window before the second sample.
    run("stall", 8'd20, 8'd30, 8'd0, 2'd2, 21);
    repeat (4) @(negedge clk);
    stall_req = 10;
    wait_done("stall");

    // Reference write and start while busy must both be ignored.
    run("ignore", 8'd20, 8'd30, 8'd0, 2'd2, 11);
    repeat (3) @(negedge clk);
    ifc.ref_wr_en   = 1'b1;
    ifc.ref_wr_addr = 2'd2;
    ifc.ref_wr_data = 8'd0;
    ifc.start       = 1'b1;
    @(negedge clk);
    ifc.ref_wr_en = 1'b0;
    ifc.start     = 1'b0;
    wait_done("ignore");
    run("ref_kept", 8'd20, 8'd30, 8'd0, 2'd2, 11);
    wait_done("ref_kept");

    // Rows [0,10,20,30] / [30,20,20,20]: nonzero tie resolves to column 1.
    run("tie20", 8'd10, 8'd40, 8'd20, 2'd1, 11);
    wait_done("tie20");

    // All-zero last row: lowest index wins.
    load_ref(8'd5, 8'd5, 8'd5, 8'd5);
    run("tie0", 8'd5, 8'd5, 8'd0, 2'd0, 11);
    wait_done("tie0");

    // 255 + 255 clamps to 255 rather than wrapping.
    load_ref(8'd0, 8'd0, 8'd0, 8'd0);
    run("sat", 8'd255, 8'd255, 8'd255, 2'd0, 11);
    wait_done("sat");
    repeat (3) @(negedge clk);
    chk("sat_hold_cost", ifc.result_cost, 255);

    load_ref(8'd10, 8'd20, 8'd30, 8'd40);
    run("pre_reset", 8'd10, 8'd40, 8'd20, 2'd1, 11);
    wait_done("pre_reset");

    // Abandon a run mid-row with an asynchronous reset.
    fifo_q.push_back(8'd20);
    fifo_q.push_back(8'd30);
    repeat (2) @(negedge clk);
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun_busy", ifc.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", ifc.busy, 0);
    chk("async_rst_done", ifc.done, 0);
    chk("async_rst_cost", ifc.result_cost, 0);
    chk("async_rst_pos", ifc.result_pos, 0);
    fifo_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_ref(8'd10, 8'd20, 8'd30, 8'd40);
    run("post_reset", 8'd20, 8'd30, 8'd0, 2'd2, 11);
    wait_done("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dtw_sdtw_core.md
Name: dtw_sdtw_core

Overview:
- Serial subsequence-DTW compute engine, directly downstream of the AXI-Stream sink's 8-bit sample FIFO.
- Pops query (squiggle) samples from that FIFO and aligns them against a reference held in a local register array.
- Computes one DP cell per clock and reports the minimum alignment cost and its end position in the reference.

Parameters:
SAMPLE_W, 8, sample width; matches the FIFO dout width (32/4).
REF_LEN, 16, number of reference samples (columns).
QUERY_LEN, 8, query samples consumed per run (rows).
COST_W, 16, accumulated cost width; all-ones = INF/saturation value.

Ports:
S_AXIS_ACLK  input  1  clock, shared with the stream sink.
S_AXIS_ARESETN  input  1  reset, asynchronous, active-low.
dtw_fifo_dout  input  SAMPLE_W  head-of-FIFO sample, valid while !dtw_fifo_empty.
dtw_fifo_empty  input  1  FIFO empty.
dtw_fifo_rden  output  1  pop strobe (combinational).
ref_wr_en  input  1  reference write strobe.
ref_wr_addr  input  clog2(REF_LEN)  reference index.
ref_wr_data  input  SAMPLE_W  reference sample.
start  input  1  begin run (pulse).
busy  output  1  high outside IDLE.
done  output  1  one-cycle pulse, run complete.
result_cost  output  COST_W  min over j of D[QUERY_LEN-1][j].
result_pos  output  clog2(REF_LEN)  argmin j (lowest index on tie).

Behaviour:
- Reset (async, active-low):
  - state=IDLE; busy=0, done=0, result_cost=0, result_pos=0.
  - Row/column counters and diag/left/min registers cleared.
  - Reference array and prev-row array are not reset; reference must be reloaded after reset.
  - Reset mid-run abandons the run; samples already popped are lost.
- States and transitions:
  - IDLE: start=1 → FETCH; clear row counter i. Ignore start while busy.
  - FETCH: dtw_fifo_rden = (state==FETCH && !dtw_fifo_empty).
    - On pop: latch q<=dout; set j=0; diag=(i==0)?0:INF; left=INF; go to ROW.
    - Empty: stall in FETCH indefinitely.
  - ROW (one cell per cycle):
    - cost=|q-ref[j]|, computed at SAMPLE_W+1 bits, zero-extended.
    - up=(i==0)?0:prev[j].
    - cell = sat(cost + min(diag, up, left)); sum in COST_W+1 bits, clamp to all-ones.
    - Then prev[j]<=cell, diag<=up, left<=cell.
    - Last row only: on j==0 or cell<min, update min<=cell and pos<=j (strict less-than).
    - j==REF_LEN-1: go to DONE if i==QUERY_LEN-1, else i++ and go to FETCH.
  - DONE: done=1 for one cycle; result_cost/result_pos registered and held until the next start; then IDLE.
- Free start: row -1 is all zeros. Column -1 is INF for all rows except D[-1][-1]=0.
- Latency with a never-empty FIFO: start sampled at cycle 0 → done high at cycle 1+QUERY_LEN*(REF_LEN+1).
- dtw_fifo_rden is never asserted outside FETCH and never while empty.
- ref_wr_en is honoured only in IDLE; ignored while busy. start and ref_wr_en in the same IDLE cycle: write takes effect, run starts.
- Each pop consumes exactly one FIFO entry.

Decomposition:
- Shared package dtw_pkg: SAMPLE_W, COST_W defaults, INF constant, state encoding (IDLE, FETCH, ROW, DONE).
- One natural sub-module: dtw_cell, combinational (abs-diff + 3-way min + saturating add).
- Control FSM, prev-row array and reference array stay in the top.

Test Plan:
- Basic run with REF_LEN=4, QUERY_LEN=2, ref=[10,20,30,40], FIFO preloaded [20,30]:
  - expect row0=[10,0,10,20], row1=[30,10,0,10];
  - result_cost=0, result_pos=2, done at cycle 11 after start, exactly 2 rden pulses.
- Saturation with COST_W=8, ref all 0, query [255,255] → result_cost=255, result_pos=0, no wrap.
- Stall: same as the basic run, but hold dtw_fifo_empty=1 for 10 cycles before the second sample:
  - rden stays 0 throughout the stall;
  - done is delayed by exactly 10 cycles; same result.
- Ignored inputs while busy:
  - ref_wr_en mid-run → reference unchanged; result identical to the basic run.
  - start mid-run → no restart.
- Tie-break: ref=[5,5,5,5], query [5,5] → all last-row cells 0 → result_pos=0.
- Reset: assert ARESETN low mid-ROW → busy/done/result outputs 0 immediately (async). A new start after reset with fresh FIFO data produces the correct result.
